// File: rtl/router_1xn.sv
// router_1xn: 1-to-N length-framed packet router with per-port FWFT
// FIFOs, header/payload parity check and per-destination stall flush.
module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int N_PORTS    = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      pkt_valid,
  output logic                      busy,
  output logic                      error,
  input  logic [N_PORTS-1:0]        read_enb,
  output logic [N_PORTS-1:0]        valid_out,
  output logic [N_PORTS*DATA_W-1:0] data_out
);

  localparam int ADDR_W =
    (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int NPAD  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] N_LIM =
    (ADDR_W + 1)'(N_PORTS);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_PARITY  = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] hdr_addr;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_ok;

  logic [N_PORTS-1:0] full;
  logic [N_PORTS-1:0] empty;
  logic [N_PORTS-1:0] rd_go;
  logic [N_PORTS-1:0] flush;
  logic [N_PORTS-1:0] wr_en;

  logic [NPAD-1:0]   full_pad;
  logic [NPAD-1:0]   rd_pad;
  logic [NPAD-1:0]   wr_pad;
  logic [ADDR_W-1:0] wr_sel;
  logic              wr_go;
  logic              busy_c;
  logic              accept;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_len  = data_in[DATA_W-1:ADDR_W];
  assign hdr_ok   = {1'b0, hdr_addr} < N_LIM;

  // Padded to 2**ADDR_W so an invalid address never indexes out of range
  always_comb begin
    full_pad = '0;
    rd_pad   = '0;
    full_pad[N_PORTS-1:0] = full;
    rd_pad[N_PORTS-1:0]   = rd_go;
  end

  always_comb begin
    case (state_q)
      S_IDLE:
        busy_c = pkt_valid & hdr_ok
               & full_pad[hdr_addr];
      S_PAYLOAD,
      S_PARITY:
        busy_c = full_pad[addr_q]
               & ~rd_pad[addr_q];
      default:
        busy_c = 1'b0;
    endcase
  end

  assign busy   = busy_c;
  assign accept = pkt_valid & ~busy_c;
  assign error  = err_q;

  always_comb begin
    wr_sel = addr_q;
    wr_go  = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_sel = hdr_addr;
        wr_go  = accept & hdr_ok;
      end
      S_PAYLOAD,
      S_PARITY:
        wr_go = accept;
      default:
        wr_go = 1'b0;
    endcase
  end

  always_comb begin
    wr_pad = '0;
    if (wr_go) begin
      wr_pad[wr_sel] = 1'b1;
    end
  end

  assign wr_en = wr_pad[N_PORTS-1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          addr_d = hdr_addr;
          rem_d  = hdr_len;
          acc_d  = data_in;
          if (!hdr_ok) begin
            state_d = S_DROP;
          end else if (hdr_len == '0) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          acc_d = acc_q ^ data_in;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          err_d   = data_in != acc_q;
          state_d = S_IDLE;
        end
        default: begin
          // len payload words plus parity: rem runs len..0
          rem_d = rem_q - 1'b1;
          if (rem_q == '0) begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wp_q, wp_d;
    logic [PTR_W:0]    rp_q, rp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              idle;

    assign empty[i] = wp_q == rp_q;
    assign full[i]  =
      (wp_q[PTR_W] != rp_q[PTR_W]) &&
      (wp_q[PTR_W-1:0] == rp_q[PTR_W-1:0]);

    assign rd_go[i] = read_enb[i] & ~empty[i];
    assign idle     = ~empty[i] & ~read_enb[i];
    assign flush[i] = idle & (cnt_q == CNT_MAX);

    always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = '0;
      if (idle && !flush[i]) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Flush wins over any read or write on the same edge
      if (flush[i]) begin
        rp_d = wp_q;
      end else begin
        if (rd_go[i]) begin
          rp_d = rp_q + 1'b1;
        end
        if (wr_en[i]) begin
          wp_d = wp_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clock) begin
      if (wr_en[i] && !flush[i]) begin
        mem_q[wp_q[PTR_W-1:0]] <= data_in;
      end
    end

    assign valid_out[i] = ~empty[i];
    assign data_out[i*DATA_W +: DATA_W] =
      empty[i] ? '0 : mem_q[rp_q[PTR_W-1:0]];
  end

endmodule

// File: doc/router_1xn.md
Name: router_1xn

Overview:
Parametrised 1-to-N packet router, successor to the fixed 1x3 router. It accepts length-framed packets on a single source port and steers each one, by its header address, into one of N_PORTS per-destination FIFOs. Each destination has its own read handshake. Destinations that stop reading are flushed after a timeout. A header/payload parity check is performed per packet. It sits between the source agent (data_in/pkt_valid/busy/error) and N destination agents (read_enb/valid_out/data_out).

Parameters:
DATA_W, 8, word width of data_in and of each data_out lane
N_PORTS, 3, number of destination ports (2..16)
FIFO_DEPTH, 16, entries per destination FIFO, power of two >= 4
TIMEOUT, 30, cycles a destination may hold valid_out without reading before it is flushed
(derived) ADDR_W = max(1, clog2(N_PORTS)); LEN_W = DATA_W - ADDR_W

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
data_in  input  DATA_W  source word (header, payload or parity)
pkt_valid  input  1  source word valid
busy  output  1  source must hold data_in; word not accepted
error  output  1  one-cycle pulse: parity mismatch on the last packet
read_enb  input  N_PORTS  per-destination pop request
valid_out  output  N_PORTS  per-destination FIFO non-empty
data_out  output  N_PORTS*DATA_W  lane i = data_out[i*DATA_W +: DATA_W], FIFO head of port i

Behaviour:
- Reset (resetn=0, asynchronous): all FIFOs empty; FSM=IDLE; valid_out=0; busy=0; error=0; data_out=0; timeout counters=0; parity accumulator=0.
- Word acceptance: a word is accepted on a rising edge when pkt_valid=1 and busy=0. pkt_valid=0 simply stalls the packet; there is no abort.
- Packet format:
  - header: addr = data_in[ADDR_W-1:0], len = data_in[DATA_W-1:ADDR_W];
  - then len payload words;
  - then 1 parity word.
  - Every word, including header and parity, is written to the destination FIFO.
- FSM states:
  - IDLE: on header accepted, latch addr and len, and set parity acc = header.
    - If addr >= N_PORTS, go to DROP.
    - Else if len=0, go to PARITY; otherwise go to PAYLOAD.
  - PAYLOAD: each accepted word XORs into acc and decrements the remaining count. The word that brings the count to 0 moves the FSM to PARITY.
  - PARITY: on accept, compare the word with acc. If unequal, error=1 in the next cycle only. Then go to IDLE.
  - DROP: accept and discard len+1 further words with busy=0, writing no FIFO and raising no error; then go to IDLE.
- busy (combinational):
  - IDLE: 1 iff pkt_valid & addr<N_PORTS & FIFO[addr] full.
  - PAYLOAD/PARITY: 1 iff the latched destination FIFO is full and not being read this cycle.
  - DROP: 0.
- FIFOs:
  - First-word-fall-through: valid_out[i] = !empty[i]; data_out lane i = head entry when valid_out[i]=1, else 0.
  - read_enb[i] with empty FIFO is ignored.
  - Simultaneous read and write on a full FIFO is allowed and keeps occupancy constant; busy stays 0 in that case.
  - Read/write pointers wrap modulo FIFO_DEPTH; one extra bit distinguishes full from empty.
- Timeout flush, per port:
  - cnt[i] increments each cycle valid_out[i]=1 & read_enb[i]=0.
  - cnt[i] clears on any read or when empty.
  - When cnt[i] reaches TIMEOUT-1 and another idle cycle occurs, FIFO i is emptied at that edge and cnt[i]=0.
  - A write to FIFO i on the flush edge is discarded. The FSM continues the packet unaffected, so the tail of the packet is still written.
- Latency: a word accepted at edge k is visible on valid_out/data_out after edge k (one cycle), including into an empty FIFO.
- error is registered. A reset asserted mid-packet discards all state immediately.

Test Plan:
- N_PORTS=3, DATA_W=8: header 0x11 (len 4, addr 1), payload 01 02 03 04, parity 0x15. Read port 1 continuously -> data_out lane1 = 11,01,02,03,04,15 in order; error stays 0; ports 0 and 2 valid_out=0.
- Same packet with parity 0x00 -> error=1 for exactly one cycle after the parity accept; all 6 words are still delivered to port 1.
- Header 0x0B (len 2, addr 3, invalid), then 2 payload words and 1 parity word -> busy=0 throughout; no valid_out; error=0. A following valid packet to port 0 routes correctly.
- Packet with len 20 to port 0 with read_enb=0 -> busy=1 after 16 accepted words. Assert read_enb[0] for 1 cycle within the timeout -> exactly one further word accepted.
- Packet of len 2 to port 2, never read -> valid_out[2] falls to 0 exactly TIMEOUT cycles after it rose; the next packet to port 2 is delivered intact.
- Assert resetn=0 mid-payload -> all outputs return to 0 immediately (asynchronous). A subsequent header 0x04 (len 1, addr 0) routes normally.
